rr_arbiter4: RTL

//  Round-robin arbiter that shares one resource among 4 requesters.

---
 rtl/rr_arb_pkg.sv | 33 +++
 rtl/rr_arbiter4_onehot4_to_bin2.sv | 21 ++
 rtl/rr_arbiter4.sv | 107 ++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types, constants and helpers for the 4-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned NREQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Owner index encoding: requester i maps to 3-i.
  localparam logic [1:0] IDX_REQ0 = 2'b11;
  localparam logic [1:0] IDX_REQ1 = 2'b10;
  localparam logic [1:0] IDX_REQ2 = 2'b01;
  localparam logic [1:0] IDX_REQ3 = 2'b00;

  // Returns {found, index} of the first set bit of v, searching ptr, ptr+1, ... (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] ptr);
    logic [1:0] c;
    logic [2:0] res;
    res = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      c = ptr + 2'(k);
      if (v[c] && !res[2]) res = {1'b1, c};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_onehot4_to_bin2.sv
// Combinational 4:2 encoder from one-hot grant to the owner index code.
module onehot4_to_bin2
  import rr_arb_pkg::*;
(
  input  logic [3:0] onehot_i,
  output logic [1:0] idx_o
);

  // Map each legal one-hot value; zero or illegal inputs fall back to 00.
  always_comb begin
    idx_o = IDX_REQ3;
    case (onehot_i)
      4'b0001: idx_o = IDX_REQ0;
      4'b0010: idx_o = IDX_REQ1;
      4'b0100: idx_o = IDX_REQ2;
      4'b1000: idx_o = IDX_REQ3;
      default: idx_o = IDX_REQ3;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for 4 requesters with a per-owner hold budget and registered outputs.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid
);

  localparam int unsigned      CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       grant_idx_q, grant_idx_d;
  logic             grant_valid_q;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [3:0] others;
  logic [3:0] cand;
  logic [2:0] pick;
  logic       owner_req;
  logic       take;
  logic       go_idle;

  // Next-state: pick a winner from ptr, decide grant/handover/preempt/idle, update hold counter.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    take      = 1'b0;
    go_idle   = 1'b0;
    others    = req & ~grant_q;
    cand      = (state_q == ST_IDLE) ? req : others;
    pick      = rr_pick(cand, ptr_q);
    owner_req = |(req & grant_q);

    unique case (state_q)
      ST_IDLE: begin
        take = pick[2];
      end
      ST_BUSY: begin
        if (!owner_req) begin
          take    = pick[2];
          go_idle = !pick[2];
        end else if ((hold_q == HOLD_MAX) && pick[2]) begin
          take = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
    endcase

    if (take) begin
      state_d = ST_BUSY;
      grant_d = onehot4(pick[1:0]);
      ptr_d   = pick[1:0] + 2'd1;
      hold_d  = HOLD_ONE;
    end else if (go_idle) begin
      state_d = ST_IDLE;
      grant_d = '0;
      hold_d  = '0;
    end
  end

  onehot4_to_bin2 u_enc (
    .onehot_i (grant_d),
    .idx_o    (grant_idx_d)
  );

  // State and output registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_idx_q   <= IDX_REQ3;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= |grant_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_valid:  assert property (@(posedge clk) disable iff (rst) grant_valid_q == (|grant_q));
  a_idx:    assert property (@(posedge clk) disable iff (rst) grant_valid_q |-> grant_q[~grant_idx_q]);
  a_idle:   assert property (@(posedge clk) disable iff (rst) !grant_valid_q |-> (grant_idx_q == IDX_REQ3));

endmodule
